// File: rtl/ctrl_seq_alu_pkg.sv
// ctrl_pkg: state encoding, opcodes, ALU codes and decode helpers for the Mini SRC sequencer
package ctrl_pkg;
  localparam int OPW = 5;
  localparam int ALUW = 4;
  typedef enum logic [2:0] {S_RST, T0, T1, T2, T3, T4, T5, S_HALT} state_t;
  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_AND  = 5'b00101;
  localparam logic [OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPW-1:0] OP_ANDI = 5'b01101;
  localparam logic [OPW-1:0] OP_ORI  = 5'b01110;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;
  localparam logic [ALUW-1:0] ALU_ADD = 4'd0;
  localparam logic [ALUW-1:0] ALU_SUB = 4'd1;
  localparam logic [ALUW-1:0] ALU_AND = 4'd2;
  localparam logic [ALUW-1:0] ALU_OR  = 4'd3;
  function automatic logic is_r(input logic [OPW-1:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
  endfunction
  function automatic logic is_i(input logic [OPW-1:0] op);
    return op inside {OP_ADDI, OP_ANDI, OP_ORI};
  endfunction
  function automatic logic [ALUW-1:0] alu_of(input logic [OPW-1:0] op);
    return (op == OP_SUB) ? ALU_SUB :
           (op == OP_AND || op == OP_ANDI) ? ALU_AND :
           (op == OP_OR || op == OP_ORI) ? ALU_OR : ALU_ADD;
  endfunction
endpackage

// File: rtl/ctrl_seq_alu_sel_encode.sv
// sel_encode: picks Ra/Rb/Rc from the IR fields and decodes it to one-hot write/read vectors
module sel_encode (
  input  logic [11:0] fields,
  input  logic        gra,
  input  logic        grb,
  input  logic        grc,
  input  logic        rin,
  input  logic        rout,
  input  logic        ba,
  output logic [15:0] GRin,
  output logic [15:0] GRout
);
  logic [3:0] sel;
  logic [15:0] dec;
  // field select then decode; BAout reads through the same selected register (R0 reads zero in the bank)
  always_comb begin
    sel = gra ? fields[11:8] : grb ? fields[7:4] : grc ? fields[3:0] : 4'd0;
    dec = 16'd1 << sel;
    GRin = rin ? dec : 16'd0;
    GRout = (rout || ba) ? dec : 16'd0;
  end
endmodule

// File: rtl/ctrl_seq_alu.sv
// ctrl_seq_alu: hardwired fetch/decode/execute sequencer for Mini SRC ALU instructions
module ctrl_seq_alu
  import ctrl_pkg::*;
#(
  parameter int OPW = 5,
  parameter int ALUW = 4
) (
  input  logic            clk,
  input  logic            clear,
  input  logic [31:0]     ir,
  input  logic            mem_ready,
  output logic [15:0]     GRin,
  output logic [15:0]     GRout,
  output logic            BAout,
  output logic            PCout,
  output logic            PCin,
  output logic            IncPC,
  output logic            MARin,
  output logic            MDRin,
  output logic            MDRout,
  output logic            Read,
  output logic            IRin,
  output logic            Yin,
  output logic            Zin,
  output logic            Zlowout,
  output logic            Cout,
  output logic [ALUW-1:0] alu_op,
  output logic            run
);
  state_t state, nxt;
  logic [OPW-1:0] op;
  logic r_op, i_op, gra, grb, grc, rin, rout;
  logic unused_ir;
  assign op = ir[31:32-OPW];
  assign r_op = is_r(op);
  assign i_op = is_i(op);
  assign unused_ir = ^ir[14:0];
  sel_encode u_sel (
    .fields(ir[26:15]),
    .gra(gra),
    .grb(grb),
    .grc(grc),
    .rin(rin),
    .rout(rout),
    .ba(BAout),
    .GRin(GRin),
    .GRout(GRout)
  );
  // state register; clear forces S_RST immediately
  always_ff @(posedge clk or posedge clear) begin
    if (clear) state <= S_RST;
    else state <= nxt;
  end
  // next state and Moore strobes decoded from state and IR opcode
  always_comb begin
    nxt = state;
    {PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin, Zin, Zlowout, Cout} = '0;
    {gra, grb, grc, rin, rout, BAout} = '0;
    alu_op = '0;
    run = (state != S_HALT);
    case (state)
      S_RST: nxt = T0;
      T0: begin
        {PCout, MARin, IncPC, Zin} = '1;
        nxt = T1;
      end
      T1: begin
        {Zlowout, PCin, Read, MDRin} = '1;
        nxt = mem_ready ? T2 : T1;
      end
      T2: begin
        {MDRout, IRin} = '1;
        nxt = T3;
      end
      T3: begin
        grb = r_op || i_op;
        rout = r_op || i_op;
        Yin = r_op || i_op;
        BAout = (op == OP_ADDI);
        nxt = (r_op || i_op) ? T4 : (op == OP_HALT) ? S_HALT : T0;
      end
      T4: begin
        grc = r_op;
        rout = r_op;
        Cout = i_op;
        alu_op = alu_of(op);
        Zin = 1'b1;
        nxt = T5;
      end
      T5: begin
        {Zlowout, gra, rin} = '1;
        nxt = T0;
      end
      default: nxt = state;
    endcase
  end
endmodule
